hit_reaction_fsm: RTL and testbench

HIT_REACTION_FSM -- requirements
Module: hit_reaction_fsm

---
 rtl/footsies_pkg.sv | 29 ++
 rtl/stun_counter.sv | 43 ++++
 rtl/hit_reaction_fsm.sv | 132 +++++++++++++
 tb/tb_hit_reaction_fsm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/footsies_pkg.sv
// Shared state encodings and frame constants for the per-player fight FSMs.
// Pure definitions: no latency, no flow control.
package footsies_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HITSTUN   = 2'd1,
        ST_BLOCKSTUN = 2'd2,
        ST_KO        = 2'd3
    } react_state_e;

    localparam int HITSTUN_FRAMES_DEF   = 20;
    localparam int BLOCKSTUN_FRAMES_DEF = 12;
    localparam int MAX_HEALTH_DEF       = 3;
    localparam int KB_FRAMES_DEF        = 6;
    localparam int KB_PX_DEF            = 2;

    localparam int HEALTH_W   = 2;
    localparam int KB_DX_W    = 4;
    localparam int STUN_CNT_W = 8;

    // Knockback pushes the player away from the side it faces.
    function automatic logic [KB_DX_W-1:0] kb_delta(input logic facing_left, input int px);
        logic [KB_DX_W-1:0] mag;
        mag = KB_DX_W'(px);
        return facing_left ? mag : (KB_DX_W'(0) - mag);
    endfunction

endpackage

// File: rtl/stun_counter.sv
// Loadable frame down-counter with zero flag; priority clr > load > decrement.
// Count updates one clk after clr/load/en; never blocks, saturates at zero.
module stun_counter
    import footsies_pkg::*;
#(
    parameter int W = STUN_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/hit_reaction_fsm.sv
// Per-player hit/block reaction: stun timing, health, KO and knockback.
// Events act one clk after their rising edge; knockback is combinational on frame_tick.
module hit_reaction_fsm
    import footsies_pkg::*;
#(
    parameter int HITSTUN_FRAMES   = HITSTUN_FRAMES_DEF,
    parameter int BLOCKSTUN_FRAMES = BLOCKSTUN_FRAMES_DEF,
    parameter int MAX_HEALTH       = MAX_HEALTH_DEF,
    parameter int KB_FRAMES        = KB_FRAMES_DEF,
    parameter int KB_PX            = KB_PX_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_tick,
    input  logic                round_reset,
    input  logic                got_hit,
    input  logic                got_blocked,
    input  logic                back_held,
    input  logic                attack_busy,
    input  logic                facing_left,
    output logic                is_blocking,
    output logic                hurtbox_active,
    output logic                stunned,
    output logic [1:0]          state,
    output logic [HEALTH_W-1:0] health,
    output logic                kb_en,
    output logic [KB_DX_W-1:0]  kb_dx,
    output logic                ko
);

    localparam logic [HEALTH_W-1:0]   HEALTH_FULL = HEALTH_W'(MAX_HEALTH);
    localparam logic [STUN_CNT_W-1:0] HIT_LOAD    = STUN_CNT_W'(HITSTUN_FRAMES);
    localparam logic [STUN_CNT_W-1:0] BLK_LOAD    = STUN_CNT_W'(BLOCKSTUN_FRAMES);
    localparam logic [STUN_CNT_W-1:0] KB_LOAD     = STUN_CNT_W'(KB_FRAMES);

    react_state_e          state_q, state_d;
    logic [HEALTH_W-1:0]   health_q, health_d, health_dec;
    logic                  hit_q, hit_d, blk_q, blk_d;
    logic                  hit_rise, blk_rise, can_react, in_stun, stun_expire;
    logic                  stun_load, kb_load;
    logic [STUN_CNT_W-1:0] stun_val, stun_cnt, kb_cnt_unused;
    logic                  stun_zero, kb_zero;

    always_comb begin
        hit_rise    = got_hit & ~hit_q;
        blk_rise    = got_blocked & ~blk_q;
        can_react   = (state_q == ST_IDLE) || (state_q == ST_BLOCKSTUN);
        in_stun     = (state_q == ST_HITSTUN) || (state_q == ST_BLOCKSTUN);
        health_dec  = (health_q == '0) ? '0 : (health_q - HEALTH_W'(1));
        // A zero count while stunned can only come from a zero-frame parameter.
        stun_expire = in_stun && (stun_zero || (frame_tick && (stun_cnt == STUN_CNT_W'(1))));
    end

    always_comb begin
        state_d   = state_q;
        health_d  = health_q;
        stun_load = 1'b0;
        stun_val  = '0;
        kb_load   = 1'b0;
        hit_d     = round_reset ? 1'b0 : got_hit;
        blk_d     = round_reset ? 1'b0 : got_blocked;
        if (round_reset) begin
            state_d  = ST_IDLE;
            health_d = HEALTH_FULL;
        end else if (can_react && hit_rise) begin
            health_d  = health_dec;
            kb_load   = 1'b1;
            stun_load = 1'b1;
            if (health_dec == '0) begin
                state_d  = ST_KO;
                stun_val = '0;
            end else begin
                state_d  = ST_HITSTUN;
                stun_val = HIT_LOAD;
            end
        end else if (can_react && blk_rise) begin
            state_d   = ST_BLOCKSTUN;
            stun_load = 1'b1;
            stun_val  = BLK_LOAD;
            kb_load   = 1'b1;
        end else if (stun_expire) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            health_q <= HEALTH_FULL;
            hit_q    <= 1'b0;
            blk_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            health_q <= health_d;
            hit_q    <= hit_d;
            blk_q    <= blk_d;
        end
    end

    stun_counter #(.W(STUN_CNT_W)) u_stun_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (round_reset),
        .load     (stun_load),
        .load_val (stun_val),
        .en       (frame_tick),
        .cnt      (stun_cnt),
        .zero     (stun_zero)
    );

    // Knockback only needs to know whether frames remain.
    stun_counter #(.W(STUN_CNT_W)) u_kb_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (round_reset),
        .load     (kb_load),
        .load_val (KB_LOAD),
        .en       (frame_tick),
        .cnt      (kb_cnt_unused),
        .zero     (kb_zero)
    );

    assign state          = state_q;
    assign health         = health_q;
    assign is_blocking    = back_held & ~attack_busy & can_react;
    assign stunned        = (state_q != ST_IDLE);
    assign hurtbox_active = (state_q != ST_KO);
    assign ko             = (state_q == ST_KO);
    assign kb_en          = frame_tick & ~kb_zero;
    assign kb_dx          = kb_en ? kb_delta(facing_left, KB_PX) : '0;

endmodule

// File: tb/tb_hit_reaction_fsm.sv
// Directed stimulus with a frame-level reference model checked every clk.
module tb_hit_reaction_fsm;

    localparam int HS   = 20;
    localparam int BS   = 12;
    localparam int MAXH = 3;
    localparam int KBF  = 6;
    localparam int KBPX = 2;

    logic       clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, round_reset = 1'b0;
    logic       got_hit = 1'b0, got_blocked = 1'b0, back_held = 1'b0;
    logic       attack_busy = 1'b0, facing_left = 1'b0;
    logic       is_blocking, hurtbox_active, stunned, kb_en, ko;
    logic [1:0] state, health;
    logic [3:0] kb_dx;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0=IDLE 1=HITSTUN 2=BLOCKSTUN 3=KO, counters in frames.
    int m_state = 0, m_health = MAXH, m_stun = 0, m_kb = 0;
    bit m_ph = 1'b0, m_pb = 1'b0;

    always #5 clk = ~clk;

    hit_reaction_fsm #(
        .HITSTUN_FRAMES   (HS),
        .BLOCKSTUN_FRAMES (BS),
        .MAX_HEALTH       (MAXH),
        .KB_FRAMES        (KBF),
        .KB_PX            (KBPX)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_tick     (frame_tick),
        .round_reset    (round_reset),
        .got_hit        (got_hit),
        .got_blocked    (got_blocked),
        .back_held      (back_held),
        .attack_busy    (attack_busy),
        .facing_left    (facing_left),
        .is_blocking    (is_blocking),
        .hurtbox_active (hurtbox_active),
        .stunned        (stunned),
        .state          (state),
        .health         (health),
        .kb_en          (kb_en),
        .kb_dx          (kb_dx),
        .ko             (ko)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always begin : scoreboard
        logic        e_kb;
        logic [3:0]  e_dx;
        logic [12:0] exp_v, act_v;
        int          n_state, n_health, n_stun, n_kb;
        bit          hr, br, react;
        @(negedge clk);
        #3;
        if (!rst_n) begin
            m_state = 0; m_health = MAXH; m_stun = 0; m_kb = 0; m_ph = 1'b0; m_pb = 1'b0;
        end
        e_kb  = frame_tick && (m_kb > 0);
        e_dx  = !e_kb ? 4'd0 : (facing_left ? 4'(KBPX) : 4'(-KBPX));
        exp_v = {2'(m_state), 2'(m_health),
                 back_held && !attack_busy && (m_state == 0 || m_state == 2),
                 m_state != 3, m_state != 0, m_state == 3, e_kb, e_dx};
        act_v = {state, health, is_blocking, hurtbox_active, stunned, ko, kb_en, kb_dx};
        n_checks++;
        if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL outputs t=%0t got=%b expected=%b (state,health,blk,hurt,stun,ko,kb_en,kb_dx)",
                     $time, act_v, exp_v);
        end
        if (rst_n) begin
            hr       = got_hit && !m_ph;
            br       = got_blocked && !m_pb;
            react    = (m_state == 0) || (m_state == 2);
            n_state  = m_state;
            n_health = m_health;
            n_kb     = (frame_tick && m_kb > 0) ? m_kb - 1 : m_kb;
            n_stun   = (frame_tick && m_stun > 0) ? m_stun - 1 : m_stun;
            if (round_reset) begin
                n_state = 0; n_health = MAXH; n_stun = 0; n_kb = 0;
            end else if (react && hr) begin
                n_health = (m_health > 0) ? m_health - 1 : 0;
                n_state  = (n_health == 0) ? 3 : 1;
                n_stun   = (n_health == 0) ? 0 : HS;
                n_kb     = KBF;
            end else if (react && br) begin
                n_state = 2; n_stun = BS; n_kb = KBF;
            end else if ((m_state == 1 || m_state == 2) && frame_tick && m_stun == 1) begin
                n_state = 0;
            end
            m_state = n_state; m_health = n_health; m_stun = n_stun; m_kb = n_kb;
            m_ph = round_reset ? 1'b0 : got_hit;
            m_pb = round_reset ? 1'b0 : got_blocked;
        end
    end

    task automatic frames(input int n);
        repeat (n) begin
            @(negedge clk); frame_tick = 1'b1;
            @(negedge clk); frame_tick = 1'b0;
        end
    endtask

    task automatic pulse(input logic h, input logic b, input logic t);
        @(negedge clk); got_hit = h; got_blocked = b; frame_tick = t;
        @(negedge clk); got_hit = 1'b0; got_blocked = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic do_round_reset;
        @(negedge clk); round_reset = 1'b1;
        @(negedge clk); round_reset = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (2) @(negedge clk);
        #3;
        chk("rst_state", state, 0);
        chk("rst_health", health, 3);
        chk("rst_kb_en", kb_en, 0);
        chk("rst_kb_dx", kb_dx, 0);
        chk("rst_ko", ko, 0);
        chk("rst_hurtbox", hurtbox_active, 1);
        chk("rst_stunned", stunned, 0);
        @(negedge clk); rst_n = 1'b1;

        // Sustained hit overlap: one event, 20 frames of hitstun.
        @(negedge clk); got_hit = 1'b1;
        @(negedge clk); #3;
        chk("hold_hit_state", state, 1);
        chk("hold_hit_health", health, 2);
        repeat (39) @(negedge clk);
        #3 chk("hold_hit_single_dec", health, 2);
        @(negedge clk); got_hit = 1'b0;
        frames(19); #3 chk("hitstun_tick19", state, 1);
        frames(1);  #3 chk("hitstun_tick20", state, 0);

        // Blockstun with knockback toward -x.
        do_round_reset; #3 chk("rr_health", health, 3);
        back_held = 1'b1; facing_left = 1'b0;
        pulse(1'b0, 1'b1, 1'b0); #3;
        chk("blk_state", state, 2);
        chk("blk_is_blocking", is_blocking, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); frame_tick = 1'b1; #3;
            chk("blk_kb_en", kb_en, (i < 6) ? 8'd1 : 8'd0);
            chk("blk_kb_dx", kb_dx, (i < 6) ? 8'b0000_1110 : 8'd0);
            if (i == 11) chk("blk_before_last", state, 2);
            @(negedge clk); frame_tick = 1'b0;
        end
        #3;
        chk("blk_idle", state, 0);
        chk("blk_health", health, 3);
        @(negedge clk); attack_busy = 1'b1; #3 chk("atk_no_block", is_blocking, 0);
        @(negedge clk); attack_busy = 1'b0; #3 chk("idle_block", is_blocking, 1);

        // Simultaneous hit and block counts as a hit; knockback toward +x.
        back_held = 1'b0; facing_left = 1'b1;
        pulse(1'b1, 1'b1, 1'b0); #3;
        chk("both_state", state, 1);
        chk("both_health", health, 2);
        @(negedge clk); frame_tick = 1'b1; #3;
        chk("both_kb_en", kb_en, 1);
        chk("both_kb_dx", kb_dx, 8'b0000_0010);
        @(negedge clk); frame_tick = 1'b0;
        frames(19); #3 chk("both_idle", state, 0);

        // Three hits to KO, KO is sticky, round_reset recovers.
        do_round_reset;
        pulse(1'b1, 1'b0, 1'b0); #3 chk("ko_hit1", health, 2);
        frames(20);
        pulse(1'b1, 1'b0, 1'b0); #3 chk("ko_hit2", health, 1);
        frames(20);
        pulse(1'b1, 1'b0, 1'b0); #3;
        chk("ko_state", state, 3);
        chk("ko_flag", ko, 1);
        chk("ko_hurtbox", hurtbox_active, 0);
        chk("ko_health", health, 0);
        frames(10); #3 chk("ko_persist", state, 3);
        pulse(1'b1, 1'b0, 1'b0); #3;
        chk("ko_hit4_health", health, 0);
        chk("ko_hit4_state", state, 3);
        do_round_reset; #3;
        chk("ko_rr_health", health, 3);
        chk("ko_rr_state", state, 0);
        chk("ko_rr_flag", ko, 0);

        // Block-string reload at stun_cnt=3, coinciding with a frame_tick.
        pulse(1'b0, 1'b1, 1'b0);
        frames(9);
        pulse(1'b0, 1'b1, 1'b1); #3 chk("reload_state", state, 2);
        frames(11); #3 chk("reload_still_blk", state, 2);
        frames(1);  #3 chk("reload_idle", state, 0);
        pulse(1'b1, 1'b0, 1'b0); #3 chk("hs_hit", health, 2);
        frames(5);
        pulse(1'b1, 1'b1, 1'b0); #3;
        chk("hs_ignore_health", health, 2);
        chk("hs_ignore_state", state, 1);
        frames(15); #3 chk("hs_idle", state, 0);

        // Asynchronous reset in the middle of hitstun, between clk edges.
        pulse(1'b1, 1'b0, 1'b0);
        frames(3);
        @(negedge clk); frame_tick = 1'b1;
        #2 chk("pre_rst_kb_en", kb_en, 1);
        rst_n = 1'b0;
        #1;
        chk("async_state", state, 0);
        chk("async_health", health, 3);
        chk("async_kb_en", kb_en, 0);
        chk("async_stunned", stunned, 0);
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        frames(25); #3 chk("post_rst_idle", state, 0);
        pulse(1'b1, 1'b0, 1'b0); #3 chk("post_rst_hit", health, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
